// File: rtl/op2_stage.sv
`default_nettype none
// ============================================================================
// Module      : op2_stage
// Description : Registered second-operand stage between decode and ALU.
//               Selects op2 from the register value or an instruction
//               immediate. Applies the shift-immediate bias and optional
//               sign extension. Results are held in a 2-entry skid buffer
//               with valid/ready handshakes on both sides.
//               Optional feature macro: OP2_FWD_EN (writeback forwarding
//               for the register select).
// Revision    : 1.0 - initial release
// ============================================================================
module op2_stage #(
    parameter int DW                = 8,
    parameter int IW                = 9,
    parameter int IMMA_W            = 3,
    parameter int IMMB_W            = 5,
    parameter int OPC_W             = 6,
    parameter logic [OPC_W-1:0] LSI_OPC = 6'b110100,
    parameter logic [OPC_W-1:0] RSI_OPC = 6'b110010,
    parameter int RA_W              = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_instr,
    input  logic [DW-1:0]   in_reg2,
    input  logic [RA_W-1:0] in_reg2_a,
    input  logic [1:0]      in_sel,
    input  logic            in_sext,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_a,
    input  logic [DW-1:0]   wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_op2,
    output logic [IW-1:0]   out_instr
);

    localparam logic [1:0] c_sel_reg  = 2'b00;
    localparam logic [1:0] c_sel_imma = 2'b01;
    localparam logic [1:0] c_sel_immb = 2'b10;

    // Slot 0 is always the head entry; slot 1 holds the second entry.
    logic [1:0]    r_count;
    logic [DW-1:0] r_op2_0, r_op2_1;
    logic [IW-1:0] r_instr_0, r_instr_1;

    logic          w_push, w_pop;
    logic          w_bias;
    logic [DW-1:0] w_reg_val;
    logic [DW-1:0] w_imma;
    logic [DW-1:0] w_immb;
    logic [DW-1:0] w_op2_new;

    assign in_ready  = (r_count != 2'd2) & ~reset;
    assign out_valid = (r_count != 2'd0);
    assign out_op2   = out_valid ? r_op2_0   : '0;
    assign out_instr = out_valid ? r_instr_0 : '0;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready;

    // Shift-immediate opcodes encode shift-1, so the amount range becomes 1..2^IMMA_W.
    assign w_bias = (in_instr[IW-1 -: OPC_W] == LSI_OPC) |
                    (in_instr[IW-1 -: OPC_W] == RSI_OPC);
    assign w_imma = {{(DW-IMMA_W){1'b0}}, in_instr[IMMA_W-1:0]} +
                    {{(DW-1){1'b0}}, w_bias};
    assign w_immb = {{(DW-IMMB_W){in_sext & in_instr[IMMB_W-1]}},
                     in_instr[IMMB_W-1:0]};

`ifdef OP2_FWD_EN
    // Writeback in the same cycle carries newer data than the register file read.
    assign w_reg_val = (wb_en && (wb_a == in_reg2_a)) ? wb_data : in_reg2;
`else
    assign w_reg_val = in_reg2;
    logic  w_unused_fwd;
    assign w_unused_fwd = ^{wb_en, wb_a, wb_data, in_reg2_a};
`endif

    // Operand mux evaluated at push time; the result is stored, not recomputed.
    always_comb begin
        w_op2_new = in_instr[DW-1:0];
        case (in_sel)
            c_sel_reg  : w_op2_new = w_reg_val;
            c_sel_imma : w_op2_new = w_imma;
            c_sel_immb : w_op2_new = w_immb;
            default    : w_op2_new = in_instr[DW-1:0];
        endcase
    end

    // Buffer occupancy and slot update; flush overrides any push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count   <= 2'd0;
            r_op2_0   <= '0;
            r_op2_1   <= '0;
            r_instr_0 <= '0;
            r_instr_1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b01: begin
                    r_count   <= r_count - 2'd1;
                    r_op2_0   <= r_op2_1;
                    r_instr_0 <= r_instr_1;
                    r_op2_1   <= '0;
                    r_instr_1 <= '0;
                end
                2'b10: begin
                    r_count <= r_count + 2'd1;
                    if (r_count == 2'd0) begin
                        r_op2_0   <= w_op2_new;
                        r_instr_0 <= in_instr;
                    end else begin
                        r_op2_1   <= w_op2_new;
                        r_instr_1 <= in_instr;
                    end
                end
                2'b11: begin
                    // Only reachable at count 1: the new entry replaces the departing head.
                    r_op2_0   <= w_op2_new;
                    r_instr_0 <= in_instr;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_op2_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_op2_stage
// Description : Directed-vector bench for op2_stage with hand-computed
//               expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_op2_stage;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, in_ready, in_sext;
    logic [8:0] in_instr, out_instr;
    logic [7:0] in_reg2, wb_data, out_op2;
    logic [1:0] in_reg2_a, wb_a, in_sel;
    logic       wb_en, out_valid, out_ready;

    int n_vec = 0;
    int n_err = 0;

    op2_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_reg2   (in_reg2),
        .in_reg2_a (in_reg2_a),
        .in_sel    (in_sel),
        .in_sext   (in_sext),
        .wb_en     (wb_en),
        .wb_a      (wb_a),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op2   (out_op2),
        .out_instr (out_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [8:0] instr,
                         input logic [7:0] reg2, input logic sext);
        in_valid = v;
        in_sel   = sel;
        in_instr = instr;
        in_reg2  = reg2;
        in_sext  = sext;
    endtask

    // Push one entry with out_ready=1, check it one cycle later, let it drain.
    task automatic vec(input string tag, input logic [1:0] sel, input logic [8:0] instr,
                       input logic [7:0] reg2, input logic sext, input logic [7:0] exp);
        drive(1'b1, sel, instr, reg2, sext);
        tick();
        drive(1'b0, 2'b00, 9'h000, 8'h00, 1'b0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, {24'd0, out_op2}, {24'd0, exp});
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_a = 2'd0; wb_data = 8'h00; in_reg2_a = 2'd0;
        drive(1'b0, 2'b00, 9'h000, 8'h00, 1'b0);
        tick(); tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op2",   {24'd0, out_op2},   32'd0);
        check("rst_instr", {23'd0, out_instr}, 32'd0);
        check("rst_ready", {31'd0, in_ready},  32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Immediate selection and bias
        drive(1'b1, 2'b01, 9'b110100_011, 8'h00, 1'b0);
        tick();
        drive(1'b0, 2'b00, 9'h000, 8'h00, 1'b0);
        check("imma_lsi_instr", {23'd0, out_instr}, 32'h1A3);
        check("imma_lsi3", {24'd0, out_op2}, 32'h04);
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        vec("imma_plain7", 2'b01, 9'b000000_111, 8'h55, 1'b0, 8'h07);
        vec("imma_lsi7",   2'b01, 9'b110100_111, 8'h55, 1'b0, 8'h08);
        vec("imma_rsi7",   2'b01, 9'b110010_111, 8'h55, 1'b0, 8'h08);
        vec("immb_zext",   2'b10, 9'b0000_10110, 8'h55, 1'b0, 8'h16);
        vec("immb_sext",   2'b10, 9'b0000_10110, 8'h55, 1'b1, 8'hF6);
        vec("immb_sext10", 2'b10, 9'b0000_10000, 8'h55, 1'b1, 8'hF0);
        vec("immb_sext_pos", 2'b10, 9'b1101_00101, 8'h55, 1'b1, 8'h05);
        vec("immfull",     2'b11, 9'h1A5, 8'h55, 1'b1, 8'hA5);
        vec("reg2",        2'b00, 9'h1A5, 8'h3C, 1'b0, 8'h3C);

        // Stall: two entries fill the buffer, head held stable
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 9'h0AA, 8'h00, 1'b0);
        tick();
        drive(1'b1, 2'b11, 9'h0BB, 8'h00, 1'b0);
        tick();
        drive(1'b0, 2'b00, 9'h000, 8'h00, 1'b0);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        check("stall_a",    {24'd0, out_op2},  32'hAA);
        tick();
        check("stall_a_hold", {24'd0, out_op2}, 32'hAA);
        out_ready = 1'b1;
        tick();
        check("order_b", {24'd0, out_op2}, 32'hBB);
        tick();
        check("empty_after_b", {31'd0, out_valid}, 32'd0);

        // Push while popping at count 1
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 9'h0C0, 8'h00, 1'b0);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 9'h0C1, 8'h00, 1'b0);
        tick();
        drive(1'b0, 2'b00, 9'h000, 8'h00, 1'b0);
        out_ready = 1'b0;
        check("pushpop_c", {24'd0, out_op2}, 32'hC1);
        check("pushpop_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("pushpop_hold", {24'd0, out_op2}, 32'hC1);

        // Flush with a same-cycle input
        flush = 1'b1;
        drive(1'b1, 2'b11, 9'h0DD, 8'h00, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 9'h000, 8'h00, 1'b0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_op2",   {24'd0, out_op2},   32'd0);
        tick();
        check("flush_dropped", {31'd0, out_valid}, 32'd0);

        // Reset with two entries buffered
        drive(1'b1, 2'b11, 9'h011, 8'h00, 1'b0);
        tick();
        drive(1'b1, 2'b11, 9'h022, 8'h00, 1'b0);
        tick();
        drive(1'b0, 2'b00, 9'h000, 8'h00, 1'b0);
        check("prerst_full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_op2",   {24'd0, out_op2},   32'd0);
        check("midrst_ready", {31'd0, in_ready},  32'd1);

        // Writeback forwarding
        out_ready = 1'b1;
        wb_en = 1'b1; wb_a = 2'd2; wb_data = 8'h22; in_reg2_a = 2'd2;
`ifdef OP2_FWD_EN
        vec("fwd_match", 2'b00, 9'h000, 8'h11, 1'b0, 8'h22);
`else
        vec("fwd_match", 2'b00, 9'h000, 8'h11, 1'b0, 8'h11);
`endif
        vec("fwd_imm_ignored", 2'b11, 9'h1A5, 8'h11, 1'b0, 8'hA5);
        wb_a = 2'd1;
        vec("fwd_addr_miss", 2'b00, 9'h000, 8'h11, 1'b0, 8'h11);
        wb_en = 1'b0; wb_a = 2'd2;
        vec("fwd_wb_off", 2'b00, 9'h000, 8'h11, 1'b0, 8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
